// File: rtl/mac_pipe.sv
// mac_pipe: three-stage multiply-accumulate pipeline.
//   S1 captures the operands, S2 forms the product, S3 accumulates it.
//   The design has no FSM: stage valid bits are its only control state.
//
// Handshake: valid-only streaming with no back-pressure. A sample is accepted
// on every rising edge where valid_in=1, and a, b and clear_acc are sampled
// on that same edge. valid_out pulses for exactly one cycle, three cycles
// later, when f/count/overflow have just taken that sample into account.
// When valid_in=0 a bubble travels down the pipe and leaves the S3 state
// untouched.
module mac_pipe #(
  parameter int IN_W   = 8,
  parameter int ACC_W  = 20,
  parameter int CNT_W  = 8,
  parameter int SQUARE = 1,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             valid_in,
  input  logic             clear_acc,
  output logic [ACC_W-1:0] f,
  output logic             valid_out,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int PW = 2 * IN_W;
  localparam int SW = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // The full product must fit in the accumulator, otherwise a single sample
  // could be silently truncated.
  if (ACC_W < PW) begin : g_width_check
    $error("mac_pipe: ACC_W must be at least 2*IN_W");
  end

  // Stage 1 registers
  logic            s1_valid;
  logic            s1_clear;
  logic [IN_W-1:0] s1_a;
  logic [IN_W-1:0] s1_b;

  // Stage 2 registers
  logic            s2_valid;
  logic            s2_clear;
  logic [PW-1:0]   s2_prod;

  // Stage 3 valid bit (drives valid_out)
  logic            s3_valid;

  // Combinational datapath
  logic [PW-1:0]   product;
  logic [SW-1:0]   sum;

  // Product of the S1 operands; b is ignored in squaring mode.
  always_comb begin
    product = '0;
    if (SQUARE != 0) begin
      product = PW'(s1_a) * PW'(s1_a);
    end else begin
      product = PW'(s1_a) * PW'(s1_b);
    end
  end

  // One extra bit so the carry out of the accumulator is visible.
  always_comb begin
    sum = {1'b0, f} + SW'(s2_prod);
  end

  // S1: capture operands and tag the sample as valid / clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_clear <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= valid_in;
      s1_clear <= valid_in & clear_acc;
      s1_a     <= a;
      s1_b     <= b;
    end
  end

  // S2: register the product and carry the control bits forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_clear <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_clear <= s1_clear;
      s2_prod  <= product;
    end
  end

  // S3: accumulate. A clearing sample restarts from its own product, so
  // samples ahead of it have already landed in the old sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid <= 1'b0;
      f        <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        if (s2_clear) begin
          f        <= ACC_W'(s2_prod);
          count    <= CNT_W'(1);
          overflow <= 1'b0;
        end else begin
          if ((SAT != 0) && sum[ACC_W]) begin
            f <= ACC_MAX;
          end else begin
            f <= sum[ACC_W-1:0];
          end
          if (count != CNT_MAX) begin
            count <= count + CNT_W'(1);
          end
          overflow <= overflow | sum[ACC_W];
        end
      end
    end
  end

  assign valid_out = s3_valid;

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: directed, table-driven bench for mac_pipe.
// Three instances share the input stimulus:
//   dut_wrap : SQUARE=1, SAT=0
//   dut_sat  : SQUARE=1, SAT=1
//   dut_ab   : SQUARE=0, SAT=0
module tb_mac_pipe;

  localparam int IN_W  = 8;
  localparam int ACC_W = 20;
  localparam int CNT_W = 8;
  localparam int EXP_W = 1 + ACC_W + CNT_W + 1;

  localparam int SEL_WRAP = 0;
  localparam int SEL_SAT  = 1;
  localparam int SEL_AB   = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [IN_W-1:0] a = '0;
  logic [IN_W-1:0] b = '0;
  logic            valid_in = 1'b0;
  logic            clear_acc = 1'b0;

  logic [ACC_W-1:0] f_wrap, f_sat, f_ab;
  logic [CNT_W-1:0] c_wrap, c_sat, c_ab;
  logic             v_wrap, v_sat, v_ab;
  logic             o_wrap, o_sat, o_ab;

  mac_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SQUARE(1), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
    .f(f_wrap), .valid_out(v_wrap), .count(c_wrap), .overflow(o_wrap)
  );

  mac_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SQUARE(1), .SAT(1)) dut_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
    .f(f_sat), .valid_out(v_sat), .count(c_sat), .overflow(o_sat)
  );

  mac_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SQUARE(0), .SAT(0)) dut_ab (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
    .f(f_ab), .valid_out(v_ab), .count(c_ab), .overflow(o_ab)
  );

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic             v;
    logic             clr;
    logic [ACC_W-1:0] ef;
    logic [CNT_W-1:0] ec;
    logic             eo;
  } vec_t;

  vec_t tbl[$];
  logic [EXP_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  function automatic void add(input logic [IN_W-1:0] a_v, input logic [IN_W-1:0] b_v,
                              input logic v_v, input logic c_v,
                              input logic [ACC_W-1:0] ef, input logic [CNT_W-1:0] ec,
                              input logic eo);
    vec_t e;
    e.a = a_v; e.b = b_v; e.v = v_v; e.clr = c_v;
    e.ef = ef; e.ec = ec; e.eo = eo;
    tbl.push_back(e);
  endfunction

  // Observed {valid_out, f, count, overflow} of the selected instance.
  function automatic logic [EXP_W-1:0] obs(input int sel);
    case (sel)
      SEL_SAT: return {v_sat, f_sat, c_sat, o_sat};
      SEL_AB:  return {v_ab, f_ab, c_ab, o_ab};
      default: return {v_wrap, f_wrap, c_wrap, o_wrap};
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic check_state(input string name, input int sel, input logic [EXP_W-1:0] exp_v);
    logic [EXP_W-1:0] act;
    act = obs(sel);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s dut%0d: got vo=%0d f=%0d cnt=%0d ovf=%0d, expected vo=%0d f=%0d cnt=%0d ovf=%0d",
               name, sel, act[EXP_W-1], act[EXP_W-2 -: ACC_W], act[CNT_W:1], act[0],
               exp_v[EXP_W-1], exp_v[EXP_W-2 -: ACC_W], exp_v[CNT_W:1], exp_v[0]);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid_in = 1'b0;
    clear_acc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives the table back-to-back, one entry per cycle, and checks entry i
  // three cycles after it was driven. The first three observations must show
  // no valid_out, which also pins the latency to exactly three cycles.
  task automatic run_table(input string name, input int sel);
    int n;
    n = tbl.size();
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check_state(name, sel, exp_q.pop_front());
      end else begin
        check_val({name, "_early_vo"}, 32'(obs(sel) >> (EXP_W - 1)), 32'd0);
      end
      if (i < n) begin
        a = tbl[i].a;
        b = tbl[i].b;
        valid_in = tbl[i].v;
        clear_acc = tbl[i].clr;
        exp_q.push_back({tbl[i].v, tbl[i].ef, tbl[i].ec, tbl[i].eo});
      end else begin
        valid_in = 1'b0;
        clear_acc = 1'b0;
      end
    end
    tbl.delete();
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    logic [ACC_W-1:0] acc;

    // Reset state of all instances
    do_reset();
    check_state("reset_wrap", SEL_WRAP, '0);
    check_state("reset_sat", SEL_SAT, '0);
    check_state("reset_ab", SEL_AB, '0);

    // Single sample: 3*3
    add(8'd3, 8'd0, 1'b1, 1'b0, 20'd9, 8'd1, 1'b0);
    run_table("single", SEL_WRAP);

    // Bubble in the middle: f holds through the gap
    do_reset();
    add(8'd1, 8'd0, 1'b1, 1'b0, 20'd1, 8'd1, 1'b0);
    add(8'd0, 8'd0, 1'b0, 1'b0, 20'd1, 8'd1, 1'b0);
    add(8'd2, 8'd0, 1'b1, 1'b0, 20'd5, 8'd2, 1'b0);
    run_table("bubble", SEL_WRAP);

    // 17 x 255^2: 16th fits (1040400), 17th wraps to 56849 and sets overflow
    do_reset();
    acc = '0;
    for (int k = 1; k <= 17; k++) begin
      acc = acc + 20'd65025;
      add(8'd255, 8'd0, 1'b1, 1'b0, acc, 8'(k), (k == 17));
    end
    run_table("wrap17", SEL_WRAP);
    check_val("wrap17_f_final", 32'(f_wrap), 32'd56849);
    check_val("sat17_f", 32'(f_sat), 32'd1048575);
    check_val("sat17_ovf", 32'(o_sat), 32'd1);
    check_val("sat17_cnt", 32'(c_sat), 32'd17);

    // Sticky overflow, then clear behind an in-flight non-clear sample
    add(8'd1, 8'd0, 1'b1, 1'b0, 20'd56850, 8'd18, 1'b1);
    add(8'd3, 8'd0, 1'b1, 1'b0, 20'd56859, 8'd19, 1'b1);
    add(8'd2, 8'd0, 1'b1, 1'b1, 20'd4, 8'd1, 1'b0);
    add(8'd3, 8'd0, 1'b1, 1'b0, 20'd13, 8'd2, 1'b0);
    add(8'd2, 8'd0, 1'b1, 1'b1, 20'd4, 8'd1, 1'b0);
    run_table("clear", SEL_WRAP);

    // clear_acc without valid_in is ignored
    add(8'd9, 8'd0, 1'b0, 1'b1, 20'd4, 8'd1, 1'b0);
    add(8'd1, 8'd0, 1'b1, 1'b0, 20'd5, 8'd2, 1'b0);
    run_table("clr_novalid", SEL_WRAP);

    // Reset mid-flight, with a sample offered in the reset cycle as well
    @(negedge clk);
    a = 8'd5; valid_in = 1'b1;
    @(negedge clk);
    a = 8'd6;
    @(negedge clk);
    a = 8'd7; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_state("midflight_wrap", SEL_WRAP, '0);
      check_val("midflight_vo_sat", 32'(v_sat), 32'd0);
      @(negedge clk);
    end

    // Two-operand mode: 10*20 twice, then 255*0 leaves f unchanged but pulses
    add(8'd10, 8'd20, 1'b1, 1'b0, 20'd200, 8'd1, 1'b0);
    add(8'd10, 8'd20, 1'b1, 1'b0, 20'd400, 8'd2, 1'b0);
    add(8'd255, 8'd0, 1'b1, 1'b0, 20'd400, 8'd3, 1'b0);
    run_table("two_op", SEL_AB);

    // Count saturates at 255 over 300 samples of a=1
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = 8'd1; clear_acc = 1'b0; valid_in = 1'b1;
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    check_state("cnt_sat_wrap", SEL_WRAP, {1'b0, 20'd300, 8'd255, 1'b0});
    check_state("cnt_sat_sat", SEL_SAT, {1'b0, 20'd300, 8'd255, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
